// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    SQUASH = 2'd2,
    HALT   = 2'd3
  } fetch_state_t;

  localparam logic [15:0] PC_INC           = 16'd2;
  localparam logic [3:0]  DEFAULT_HALT_OPC = 4'hF;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, downstream and redirect signals.
interface fetch_unit_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        id_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus2, halted,
    input  imem_rdy, imem_rdata, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus2, halted,
    output imem_rdy, imem_rdata, id_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// 16-bit address register with write enable and a parameterised reset value.
module fetch_pc_reg #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [15:0] i_d,
  output logic [15:0] o_q
);

  logic [15:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VAL;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory requests, redirect squash
// and HLT detection feeding the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OPC = DEFAULT_HALT_OPC
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  fetch_state_t r_state, w_state_nxt;

  logic [15:0] w_pc, w_req_pc, w_if_pc, w_pc_d;
  logic        w_issue, w_capture, w_halt_hit, w_pc_we;
  logic        r_if_valid, r_halted;
  logic [15:0] r_if_instr, r_if_pc_plus2;

  fetch_pc_reg #(.RESET_VAL(RESET_PC)) u_pc_reg (
    .clk(clk), .rst_n(rst_n), .i_we(w_pc_we), .i_d(w_pc_d), .o_q(w_pc)
  );

  fetch_pc_reg #(.RESET_VAL(16'h0000)) u_req_pc (
    .clk(clk), .rst_n(rst_n), .i_we(w_issue), .i_d(w_pc), .o_q(w_req_pc)
  );

  fetch_pc_reg #(.RESET_VAL(16'h0000)) u_if_pc (
    .clk(clk), .rst_n(rst_n), .i_we(w_capture), .i_d(w_req_pc), .o_q(w_if_pc)
  );

  // Issue is gated by rst_n so no strobe escapes while reset is held.
  always_comb begin
    w_issue    = 1'b0;
    w_capture  = 1'b0;
    w_halt_hit = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_d     = w_pc + PC_INC;
    w_issue    = rst_n & (r_state == REQ) & ~bus.redirect &
                 (~r_if_valid | bus.id_ready);
    w_capture  = (r_state == WAIT) & bus.imem_rdy & ~bus.redirect;
    w_halt_hit = (bus.imem_rdata[15:12] == HALT_OPC);
    w_pc_we    = bus.redirect | w_issue;
    if (bus.redirect) begin
      w_pc_d = bus.redirect_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.redirect) begin
      case (r_state)
        WAIT, SQUASH: w_state_nxt = bus.imem_rdy ? REQ : SQUASH;
        default:      w_state_nxt = REQ;
      endcase
    end else begin
      case (r_state)
        REQ:     if (w_issue) w_state_nxt = WAIT;
        WAIT:    if (bus.imem_rdy) w_state_nxt = w_halt_hit ? HALT : REQ;
        SQUASH:  if (bus.imem_rdy) w_state_nxt = REQ;
        HALT:    w_state_nxt = HALT;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirect outranks both capture and drain of the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_valid    <= 1'b0;
      r_if_instr    <= 16'h0000;
      r_if_pc_plus2 <= 16'h0000;
      r_halted      <= 1'b0;
    end else begin
      if (bus.redirect) begin
        r_if_valid <= 1'b0;
      end else if (w_capture) begin
        r_if_valid <= 1'b1;
      end else if (r_if_valid && bus.id_ready) begin
        r_if_valid <= 1'b0;
      end
      if (w_capture) begin
        r_if_instr    <= bus.imem_rdata;
        r_if_pc_plus2 <= w_req_pc + PC_INC;
      end
      if (bus.redirect) begin
        r_halted <= 1'b0;
      end else if (w_capture && w_halt_hit) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign bus.imem_req    = w_issue;
  assign bus.imem_addr   = w_pc;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_instr    = r_if_instr;
  assign bus.if_pc       = w_if_pc;
  assign bus.if_pc_plus2 = r_if_pc_plus2;
  assign bus.halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a variable-latency memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  logic [15:0] ovr_addr = 16'hFFFF;
  logic [15:0] ovr_data = 16'h0000;
  int          pending = 0;
  logic [15:0] pend_addr = 16'h0000;
  int          req_count = 0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(16'h0000), .HALT_OPC(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory answers mem_lat cycles after a request; default data is {1, addr[11:0]}.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      pending      = 0;
      bus.imem_rdy = 1'b0;
    end else begin
      bus.imem_rdy = 1'b0;
      if (pending > 0) begin
        pending = pending - 1;
        if (pending == 0) begin
          bus.imem_rdy   = 1'b1;
          bus.imem_rdata = (pend_addr == ovr_addr) ? ovr_data : {4'h1, pend_addr[11:0]};
        end
      end
      if (bus.imem_req === 1'b1) begin
        pending   = mem_lat;
        pend_addr = bus.imem_addr;
        req_count = req_count + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_instr(input logic [15:0] ins);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.if_valid === 1'b1 && bus.if_instr === ins) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL wait_instr: instr %h never presented (last %h valid %b)",
               ins, bus.if_instr, bus.if_valid);
    end
  endtask

  task test_reset;
    rst_n           = 1'b0;
    bus.id_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.imem_rdy    = 1'b0;
    bus.imem_rdata  = 16'h0000;
    #2;
    checks++;
    if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.if_pc_plus2, bus.halted, bus.imem_req} !== 51'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid %b instr %h pc %h pc2 %h halted %b req %b want all 0",
               bus.if_valid, bus.if_instr, bus.if_pc, bus.if_pc_plus2, bus.halted, bus.imem_req);
    end
    tick();
    tick();
    checks++;
    if (bus.imem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: req %b valid %b want 0 0", bus.imem_req, bus.if_valid);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL first_req: req %b addr %h want 1 0000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task test_sequential;
    tick();
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seq_wait_noreq: req %b want 0", bus.imem_req);
    end
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_instr !== 16'h1000 || bus.if_pc !== 16'h0000 ||
        bus.if_pc_plus2 !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL seq_first_out: valid %b instr %h pc %h pc2 %h want 1 1000 0000 0002",
               bus.if_valid, bus.if_instr, bus.if_pc, bus.if_pc_plus2);
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL seq_second_req: req %b addr %h want 1 0002", bus.imem_req, bus.imem_addr);
    end
    tick();
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seq_drained: valid %b want 0", bus.if_valid);
    end
    tick();
    checks++;
    if (bus.if_pc !== 16'h0002 || bus.if_pc_plus2 !== 16'h0004 || bus.imem_req !== 1'b1 ||
        bus.imem_addr !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL seq_second_out: pc %h pc2 %h req %b addr %h want 0002 0004 1 0004",
               bus.if_pc, bus.if_pc_plus2, bus.imem_req, bus.imem_addr);
    end
  endtask

  task test_stall;
    ovr_addr = 16'h0004;
    ovr_data = 16'hA123;
    wait_instr(16'hA123);
    bus.id_ready = 1'b0;
    #1;
    checks++;
    if (bus.if_pc !== 16'h0004 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_start: pc %h req %b want 0004 0", bus.if_pc, bus.imem_req);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.if_valid !== 1'b1 || bus.if_instr !== 16'hA123 || bus.imem_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold: cycle %0d valid %b instr %h req %b want 1 a123 0",
                 i, bus.if_valid, bus.if_instr, bus.imem_req);
      end
    end
    bus.id_ready = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0006) begin
      errors++;
      $display("[TB] FAIL stall_release: req %b addr %h want 1 0006", bus.imem_req, bus.imem_addr);
    end
    ovr_addr = 16'hFFFF;
  endtask

  task test_redirect_wait;
    mem_lat  = 3;
    ovr_addr = 16'h0006;
    ovr_data = 16'hBEEF;
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redir_wait_noreq: req %b want 0", bus.imem_req);
    end
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redir_squash: valid %b req %b want 0 0", bus.if_valid, bus.imem_req);
    end
    tick();
    tick();
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL redir_wait_next: valid %b req %b addr %h want 0 1 0100",
               bus.if_valid, bus.imem_req, bus.imem_addr);
    end
    mem_lat  = 1;
    ovr_addr = 16'h0100;
    ovr_data = 16'h1234;
  endtask

  task test_redirect_rdy;
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    #1;
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040) begin
      errors++;
      $display("[TB] FAIL redir_rdy_next: valid %b req %b addr %h want 0 1 0040",
               bus.if_valid, bus.imem_req, bus.imem_addr);
    end
    ovr_addr = 16'hFFFF;
    tick();
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL redir_rdy_dropped: valid %b instr %h want 0", bus.if_valid, bus.if_instr);
    end
    tick();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_instr !== 16'h1040 || bus.if_pc !== 16'h0040) begin
      errors++;
      $display("[TB] FAIL redir_rdy_out: valid %b instr %h pc %h want 1 1040 0040",
               bus.if_valid, bus.if_instr, bus.if_pc);
    end
  endtask

  task test_halt;
    int saved;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0010;
    ovr_addr        = 16'h0010;
    ovr_data        = 16'hF000;
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0010) begin
      errors++;
      $display("[TB] FAIL halt_req: req %b addr %h want 1 0010", bus.imem_req, bus.imem_addr);
    end
    wait_instr(16'hF000);
    checks++;
    if (bus.if_pc !== 16'h0010 || bus.halted !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_out: pc %h halted %b req %b want 0010 1 0",
               bus.if_pc, bus.halted, bus.imem_req);
    end
    saved = req_count;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (req_count !== saved || bus.halted !== 1'b1 || bus.if_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_idle: reqs %0d halted %b valid %b want %0d 1 0",
               req_count, bus.halted, bus.if_valid, saved);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0020;
    ovr_addr        = 16'hFFFF;
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (bus.halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0020) begin
      errors++;
      $display("[TB] FAIL halt_exit: halted %b req %b addr %h want 0 1 0020",
               bus.halted, bus.imem_req, bus.imem_addr);
    end
    wait_instr(16'h1020);
    checks++;
    if (bus.if_pc !== 16'h0020) begin
      errors++;
      $display("[TB] FAIL halt_exit_pc: pc %h want 0020", bus.if_pc);
    end
  endtask

  task test_wrap;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'hFFFE) begin
      errors++;
      $display("[TB] FAIL wrap_req: req %b addr %h want 1 fffe", bus.imem_req, bus.imem_addr);
    end
    wait_instr(16'h1FFE);
    checks++;
    if (bus.if_pc !== 16'hFFFE || bus.if_pc_plus2 !== 16'h0000 || bus.imem_req !== 1'b1 ||
        bus.imem_addr !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL wrap_out: pc %h pc2 %h req %b addr %h want fffe 0000 1 0000",
               bus.if_pc, bus.if_pc_plus2, bus.imem_req, bus.imem_addr);
    end
  endtask

  task test_reset_mid;
    mem_lat = 3;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.if_pc_plus2, bus.halted, bus.imem_req} !== 51'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: valid %b instr %h pc %h pc2 %h halted %b req %b want all 0",
               bus.if_valid, bus.if_instr, bus.if_pc, bus.if_pc_plus2, bus.halted, bus.imem_req);
    end
    tick();
    tick();
    rst_n   = 1'b1;
    mem_lat = 1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_req: req %b addr %h want 1 0000", bus.imem_req, bus.imem_addr);
    end
    wait_instr(16'h1000);
    checks++;
    if (bus.if_pc !== 16'h0000 || bus.if_pc_plus2 !== 16'h0002) begin
      errors++;
      $display("[TB] FAIL reset_mid_out: pc %h pc2 %h want 0000 0002", bus.if_pc, bus.if_pc_plus2);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_rdy();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
